// File: rtl/hermes_input_buffer.sv
// Hermes router input buffer: credit-based link FIFO feeding the crossbar.
// Requests a route for each packet header, then streams header, size and
// payload flits under per-flit acknowledge, flagging the last flit read.
module hermes_input_buffer #(
    parameter int unsigned FLIT_SIZE   = 32,
    parameter int unsigned BUFFER_SIZE = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    input  logic [FLIT_SIZE-1:0] data_i,
    output logic                 credit_o,
    output logic                 req_o,
    input  logic                 ack_h_i,
    output logic                 data_av_o,
    output logic [FLIT_SIZE-1:0] data_o,
    input  logic                 data_ack_i,
    output logic                 sender_o,
    output logic                 eop_o
);

    localparam int unsigned PtrW = $clog2(BUFFER_SIZE);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(BUFFER_SIZE);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StHeader,
        StSize,
        StPayload
    } state_e;

    state_e                 state_q, state_d;
    logic [FLIT_SIZE-1:0]   storage_q [BUFFER_SIZE];
    logic [PtrW-1:0]        rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]        count_q;
    logic [FLIT_SIZE-1:0]   pay_cnt_q, pay_cnt_d;
    logic                   wr_en, rd_en;

    // A flit is only accepted while a credit is advertised; full-buffer arrivals are dropped.
    assign credit_o = (count_q != Full);
    assign wr_en    = rx_i && credit_o;
    assign rd_en    = data_av_o && data_ack_i;
    assign data_o   = storage_q[rd_ptr_q];
    assign sender_o = (state_q == StHeader) || (state_q == StSize) || (state_q == StPayload);

    // Flit storage, written at the tail.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            storage_q <= '{default: '0};
        end else if (wr_en) begin
            storage_q[wr_ptr_q] <= data_i;
        end
    end

    // Head/tail pointers; power-of-two depth makes the wrap implicit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    // Occupancy: a simultaneous write and read leaves it unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            unique case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Packet FSM state and remaining-payload counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            pay_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pay_cnt_q <= pay_cnt_d;
        end
    end

    // Packet FSM next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        pay_cnt_d = pay_cnt_q;
        req_o     = 1'b0;
        data_av_o = 1'b0;
        eop_o     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                req_o = 1'b1;
                if (ack_h_i) begin
                    state_d = StHeader;
                end
            end
            StHeader: begin
                // The header that raised the request is still at the head.
                data_av_o = 1'b1;
                if (data_ack_i) begin
                    state_d = StSize;
                end
            end
            StSize: begin
                data_av_o = (count_q != '0);
                if ((count_q != '0) && data_ack_i) begin
                    pay_cnt_d = data_o;
                    if (data_o == '0) begin
                        eop_o   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StPayload;
                    end
                end
            end
            StPayload: begin
                // Starvation mid-packet simply holds state and counter.
                data_av_o = (count_q != '0);
                if ((count_q != '0) && data_ack_i) begin
                    pay_cnt_d = pay_cnt_q - FLIT_SIZE'(1);
                    if (pay_cnt_q == FLIT_SIZE'(1)) begin
                        eop_o   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_hermes_input_buffer.sv
// Scoreboard bench for hermes_input_buffer: every accepted flit is queued with
// its expected end-of-packet flag and compared when the DUT reads it out.
module tb_hermes_input_buffer;

    localparam int FS = 32;
    localparam int BS = 8;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          rx_i = 1'b0;
    logic [FS-1:0] data_i = '0;
    logic          ack_h_i = 1'b0;
    logic          data_ack_i = 1'b0;
    logic          credit_o, req_o, data_av_o, sender_o, eop_o;
    logic [FS-1:0] data_o;

    hermes_input_buffer #(.FLIT_SIZE(FS), .BUFFER_SIZE(BS)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .rx_i       (rx_i),
        .data_i     (data_i),
        .credit_o   (credit_o),
        .req_o      (req_o),
        .ack_h_i    (ack_h_i),
        .data_av_o  (data_av_o),
        .data_o     (data_o),
        .data_ack_i (data_ack_i),
        .sender_o   (sender_o),
        .eop_o      (eop_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FS-1:0] d;
        logic          eop;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cnt_m   = 0;
    int   n_reads = 0;
    bit   auto_ack = 1'b0;
    bit   wr_eop = 1'b0;
    bit   m_wr, m_rd;
    exp_t m_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: model occupancy, check credit, pop/compare on each read handshake.
    always @(negedge clk) begin
        if (!rst_ni) begin
            sb.delete();
            cnt_m = 0;
        end else begin
            m_wr = rx_i && (cnt_m != BS);
            m_rd = data_av_o && data_ack_i;
            check("credit", 32'(credit_o), 32'(cnt_m != BS));
            if (m_rd) begin
                n_reads++;
                if (sb.size() == 0) begin
                    check("read_unexpected", 32'(m_rd), 32'd0);
                end else begin
                    m_e = sb.pop_front();
                    check("data", data_o, m_e.d);
                    check("eop", 32'(eop_o), 32'(m_e.eop));
                end
            end else begin
                check("eop_no_read", 32'(eop_o), 32'd0);
            end
            if (m_wr) begin
                m_e.d   = data_i;
                m_e.eop = wr_eop;
                sb.push_back(m_e);
            end
            cnt_m = cnt_m + int'(m_wr) - int'(m_rd);
        end
    end

    // Optional automatic route grant, answering req_o within its own cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_ack) ack_h_i = req_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_flit(input logic [FS-1:0] d, input bit eop);
        int guard = 0;
        while (cnt_m == BS && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) check("credit_timeout", 32'(guard), 32'd0);
        rx_i   = 1'b1;
        data_i = d;
        wr_eop = eop;
        tick();
        rx_i = 1'b0;
    endtask

    task automatic send_packet(input logic [FS-1:0] hdr, input int size, input logic [FS-1:0] base);
        write_flit(hdr, 1'b0);
        write_flit(FS'(size), size == 0);
        for (int i = 0; i < size; i++) begin
            write_flit(base + FS'(i), i == size - 1);
        end
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        while (sb.size() != 0 && i < budget) begin
            tick();
            i++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic pulse_ack();
        ack_h_i = 1'b1;
        tick();
        ack_h_i = 1'b0;
    endtask

    initial begin
        int r0;
        int g;

        // Reset values
        repeat (3) tick();
        check("rst_credit", 32'(credit_o), 32'd1);
        check("rst_req", 32'(req_o), 32'd0);
        check("rst_data_av", 32'(data_av_o), 32'd0);
        check("rst_data", data_o, 32'd0);
        check("rst_sender", 32'(sender_o), 32'd0);
        check("rst_eop", 32'(eop_o), 32'd0);
        rst_ni = 1'b1;
        tick();

        // Basic packet with manual grant
        data_ack_i = 1'b1;
        check("basic_req_idle", 32'(req_o), 32'd0);
        send_packet(32'h11, 2, 32'hA);
        check("basic_req", 32'(req_o), 32'd1);
        check("basic_no_av", 32'(data_av_o), 32'd0);
        tick();
        check("basic_req_hold", 32'(req_o), 32'd1);
        pulse_ack();
        check("basic_av0", 32'(data_av_o), 32'd1);
        check("basic_hdr", data_o, 32'h11);
        check("basic_req_drop", 32'(req_o), 32'd0);
        check("basic_sender", 32'(sender_o), 32'd1);
        tick();
        check("basic_size", data_o, 32'h2);
        tick();
        check("basic_p0", data_o, 32'hA);
        check("basic_p0_eop", 32'(eop_o), 32'd0);
        tick();
        check("basic_p1", data_o, 32'hB);
        check("basic_p1_eop", 32'(eop_o), 32'd1);
        tick();
        check("basic_sender_end", 32'(sender_o), 32'd0);
        check("basic_av_end", 32'(data_av_o), 32'd0);

        // Zero-size packet: two reads, eop on the size flit
        auto_ack = 1'b1;
        r0 = n_reads;
        send_packet(32'h22, 0, 32'h0);
        wait_drain(50);
        repeat (2) tick();
        check("zero_reads", 32'(n_reads - r0), 32'd2);
        check("zero_sender", 32'(sender_o), 32'd0);

        // Fill to full, drop one, then stream across the pointer wrap
        auto_ack   = 1'b0;
        ack_h_i    = 1'b0;
        data_ack_i = 1'b0;
        write_flit(32'h33, 1'b0);
        write_flit(32'd30, 1'b0);
        for (int i = 0; i < 6; i++) write_flit(32'h100 + 32'(i), 1'b0);
        check("full_credit", 32'(credit_o), 32'd0);
        rx_i   = 1'b1;
        data_i = 32'hDEAD;
        wr_eop = 1'b0;
        tick();
        rx_i = 1'b0;
        check("full_drop_credit", 32'(credit_o), 32'd0);
        auto_ack   = 1'b1;
        data_ack_i = 1'b1;
        g = 0;
        while (!data_av_o && g < 50) begin
            tick();
            g++;
        end
        check("full_hdr_av", 32'(data_av_o), 32'd1);
        tick();
        for (int i = 6; i < 30; i++) begin
            write_flit(32'h100 + 32'(i), i == 29);
            check("wrap_credit", 32'(credit_o), 32'd1);
            check("wrap_av", 32'(data_av_o), 32'd1);
        end
        wait_drain(50);

        // Mid-packet starvation
        write_flit(32'h44, 1'b0);
        write_flit(32'd4, 1'b0);
        write_flit(32'h201, 1'b0);
        write_flit(32'h202, 1'b0);
        wait_drain(50);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("starve_av", 32'(data_av_o), 32'd0);
            check("starve_sender", 32'(sender_o), 32'd1);
            check("starve_eop", 32'(eop_o), 32'd0);
        end
        write_flit(32'h203, 1'b0);
        write_flit(32'h204, 1'b1);
        wait_drain(50);
        tick();
        check("starve_done", 32'(sender_o), 32'd0);

        // Back-to-back packets
        auto_ack = 1'b0;
        ack_h_i  = 1'b0;
        send_packet(32'h55, 1, 32'h301);
        send_packet(32'h66, 1, 32'h302);
        pulse_ack();
        g = 0;
        while (!eop_o && g < 20) begin
            tick();
            g++;
        end
        check("b2b_eop1", 32'(eop_o), 32'd1);
        tick();
        check("b2b_idle_req", 32'(req_o), 32'd0);
        check("b2b_idle_av", 32'(data_av_o), 32'd0);
        tick();
        check("b2b_req2", 32'(req_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("b2b_no_early", 32'(data_av_o), 32'd0);
            tick();
        end
        pulse_ack();
        check("b2b_hdr2", data_o, 32'h66);
        wait_drain(50);

        // Reset mid-packet, then a normal packet
        auto_ack   = 1'b1;
        data_ack_i = 1'b0;
        write_flit(32'h77, 1'b0);
        write_flit(32'd3, 1'b0);
        write_flit(32'h401, 1'b0);
        repeat (3) tick();
        check("mid_sender_pre", 32'(sender_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_credit", 32'(credit_o), 32'd1);
        check("mid_rst_av", 32'(data_av_o), 32'd0);
        check("mid_rst_sender", 32'(sender_o), 32'd0);
        check("mid_rst_req", 32'(req_o), 32'd0);
        check("mid_rst_data", data_o, 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        data_ack_i = 1'b1;
        send_packet(32'h88, 1, 32'h501);
        wait_drain(50);
        tick();
        check("post_rst_sender", 32'(sender_o), 32'd0);

        repeat (3) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
